// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: qualifies raw write/read requests against the status flags and
// keeps the wrap-bit write/read pointers for a 2^ADDR_W deep FIFO.
// Optional occupancy and peak-watermark tracking is built when FIFO_PTR_LEVEL_EN is defined.
module fifo_ptr_ctrl #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic              fifo_full,
    input  logic              fifo_empty,
`ifdef FIFO_PTR_LEVEL_EN
    input  logic              peak_clr,
    output logic [ADDR_W:0]   fifo_level,
    output logic [ADDR_W:0]   fifo_peak,
`endif
    output logic              fifo_we,
    output logic              fifo_rd,
    output logic [ADDR_W:0]   wptr,
    output logic [ADDR_W:0]   rptr
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] rptr_q, rptr_d;

    // Gate raw requests with the status flags; full+empty together blocks both sides.
    always_comb begin
        fifo_we = wr & ~fifo_full;
        fifo_rd = rd & ~fifo_empty;
    end

    // Next pointer values; natural overflow of the ADDR_W+1 bit field gives the wrap.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (fifo_we) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (fifo_rd) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    // Pointer registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    assign wptr = wptr_q;
    assign rptr = rptr_q;

`ifdef FIFO_PTR_LEVEL_EN
    logic [ADDR_W:0] level_q, level_d;
    logic [ADDR_W:0] peak_q, peak_d;

    // Occupancy follows the qualified enables; peak tracks the max of the upcoming level.
    always_comb begin
        level_d = level_q;
        case ({fifo_we, fifo_rd})
            2'b10:   level_d = level_q + PTR_ONE;
            2'b01:   level_d = level_q - PTR_ONE;
            default: level_d = level_q;
        endcase
        peak_d = peak_q;
        if (peak_clr) begin
            peak_d = level_d;
        end else if (level_d > peak_q) begin
            peak_d = level_d;
        end
    end

    // Level and peak registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            peak_q  <= '0;
        end else begin
            level_q <= level_d;
            peak_q  <= peak_d;
        end
    end

    assign fifo_level = level_q;
    assign fifo_peak  = peak_q;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb_fifo_ptr_ctrl: randomized and directed checks of fifo_ptr_ctrl against an
// occupancy-counting reference model that also acts as the status-signal stage.
module tb_fifo_ptr_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr = 1'b0;
    logic              rd = 1'b0;
    logic              peak_clr = 1'b0;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_we;
    logic              fifo_rd;
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
`ifdef FIFO_PTR_LEVEL_EN
    logic [ADDR_W:0]   fifo_level;
    logic [ADDR_W:0]   fifo_peak;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: item counts and pointer positions as plain integers.
    int m_w = 0;
    int m_r = 0;
    int m_lvl = 0;
    int m_peak = 0;
    int nxt_lvl;
    bit w_ok, r_ok;

    // Status-stage override, used only to present the illegal full+empty pair.
    bit ovr = 1'b0;
    bit ovr_full = 1'b0;
    bit ovr_empty = 1'b0;

    assign fifo_full  = ovr ? ovr_full  : (m_lvl >= DEPTH);
    assign fifo_empty = ovr ? ovr_empty : (m_lvl <= 0);

    fifo_ptr_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr),
        .rd         (rd),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
`ifdef FIFO_PTR_LEVEL_EN
        .peak_clr   (peak_clr),
        .fifo_level (fifo_level),
        .fifo_peak  (fifo_peak),
`endif
        .fifo_we    (fifo_we),
        .fifo_rd    (fifo_rd),
        .wptr       (wptr),
        .rptr       (rptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: an accepted write/read moves a pointer and the item count.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_w    <= 0;
            m_r    <= 0;
            m_lvl  <= 0;
            m_peak <= 0;
        end else begin
            w_ok    = wr && !fifo_full;
            r_ok    = rd && !fifo_empty;
            nxt_lvl = m_lvl + (w_ok ? 1 : 0) - (r_ok ? 1 : 0);
            m_w   <= (m_w + (w_ok ? 1 : 0)) % PMOD;
            m_r   <= (m_r + (r_ok ? 1 : 0)) % PMOD;
            m_lvl <= nxt_lvl;
            if (peak_clr || nxt_lvl > m_peak) begin
                m_peak <= nxt_lvl;
            end
        end
    end

    // Every-cycle comparison, on the falling edge.
    always @(negedge clk) begin
        check("fifo_we", {31'd0, fifo_we}, {31'd0, wr && !fifo_full});
        check("fifo_rd", {31'd0, fifo_rd}, {31'd0, rd && !fifo_empty});
        check("wptr", 32'(wptr), 32'(m_w));
        check("rptr", 32'(rptr), 32'(m_r));
`ifdef FIFO_PTR_LEVEL_EN
        check("fifo_level", 32'(fifo_level), 32'(m_lvl));
        check("fifo_peak", 32'(fifo_peak), 32'(m_peak));
`endif
    end

    task automatic step(input bit w, input bit r);
        wr = w;
        rd = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr = 1'b0;
        rd = 1'b0;
        peak_clr = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_wptr", 32'(wptr), 32'd0);
        check("reset_rptr", 32'(rptr), 32'd0);

        // Read while empty after reset is dropped.
        rd = 1'b1;
        #1;
        check("rd_when_empty_en", {31'd0, fifo_rd}, 32'd0);
        step(1'b0, 1'b1);
        check("rd_when_empty_rptr", 32'(rptr), 32'd0);

        // Illegal full+empty pair blocks both sides.
        ovr = 1'b1; ovr_full = 1'b1; ovr_empty = 1'b1;
        wr = 1'b1; rd = 1'b1;
        #1;
        check("illegal_we", {31'd0, fifo_we}, 32'd0);
        check("illegal_rd", {31'd0, fifo_rd}, 32'd0);
        step(1'b1, 1'b1);
        check("illegal_wptr", 32'(wptr), 32'd0);
        ovr = 1'b0;

        // Sixteen writes fill the FIFO; a seventeenth is blocked.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        check("full_wptr", 32'(wptr), 32'd16);
        wr = 1'b1;
        #1;
        check("full_we_blocked", {31'd0, fifo_we}, 32'd0);
        step(1'b1, 1'b0);
        check("full_wptr_hold", 32'(wptr), 32'd16);
        // Full with a concurrent read: the read proceeds, the write is still dropped.
        step(1'b1, 1'b1);
        check("full_rd_wptr", 32'(wptr), 32'd16);
        check("full_rd_rptr", 32'(rptr), 32'd1);

        // Simultaneous write and read at level 5.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("wr_rd_wptr", 32'(wptr), 32'd6);
        check("wr_rd_rptr", 32'(rptr), 32'd1);
`ifdef FIFO_PTR_LEVEL_EN
        check("wr_rd_level", 32'(fifo_level), 32'd5);
`endif

        // Forty write-then-read pairs wrap both pointers once.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b1);
        end
        check("wrap_wptr", 32'(wptr), 32'd8);
        check("wrap_rptr", 32'(rptr), 32'd8);
`ifdef FIFO_PTR_LEVEL_EN
        check("wrap_level", 32'(fifo_level), 32'd0);

        // Peak watermark and its clear.
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1);
        check("peak_12", 32'(fifo_peak), 32'd12);
        check("peak_level_3", 32'(fifo_level), 32'd3);
        peak_clr = 1'b1;
        step(1'b0, 1'b0);
        peak_clr = 1'b0;
        check("peak_clr_3", 32'(fifo_peak), 32'd3);
`endif

        // Reset asserted mid-burst between clock edges clears immediately.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        wr = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_wptr", 32'(wptr), 32'd0);
        check("async_rst_rptr", 32'(rptr), 32'd0);
`ifdef FIFO_PTR_LEVEL_EN
        check("async_rst_level", 32'(fifo_level), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b0);
        check("resume_wptr", 32'(wptr), 32'd1);

        // Randomized traffic in phases biased toward filling, draining and balance.
        do_reset();
        for (int ph = 0; ph < 6; ph++) begin
            int unsigned wp, rp;
            wp = (ph % 3 == 0) ? 85 : ((ph % 3 == 1) ? 15 : 50);
            rp = 100 - wp;
            for (int c = 0; c < 400; c++) begin
                peak_clr = ($urandom_range(0, 31) == 0);
                wr = ($urandom_range(0, 99) < wp);
                rd = ($urandom_range(0, 99) < rp);
                if ($urandom_range(0, 299) == 0) begin
                    #3;
                    rst = 1'b1;
                    #1;
                    check("rand_rst_wptr", 32'(wptr), 32'd0);
                    check("rand_rst_rptr", 32'(rptr), 32'd0);
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wr = 1'b0;
        rd = 1'b0;
        peak_clr = 1'b0;
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
